// File: rtl/sync_level2pulse_mc.sv
`default_nettype none
// ============================================================================
// Module   : sync_level2pulse_mc
// Purpose  : Multi-channel level-to-pulse synchroniser. Each asynchronous
//            level input goes through a SYNC_STAGES flop chain, a debounce
//            filter with a shared threshold and an edge detector with a
//            per-channel edge mode. Qualified edges give a one-cycle pulse
//            and set a sticky pending flag that software clears.
// Ports    : clk        destination-domain clock
//            rst_b      asynchronous active-low reset
//            sync_in    [CH_NUM]   asynchronous level inputs
//            edge_mode  [2*CH_NUM] per channel: 00 rise, 01 fall, 10 both,
//                                  11 disabled
//            filt_cnt   [FILT_W]   debounce threshold (0/1 = no filtering)
//            evt_clr    [CH_NUM]   per-channel clear of evt_pend
//            sync_out   [CH_NUM]   one-cycle pulse per qualified edge
//            sync_ack   [CH_NUM]   filtered synchronised level
//            evt_pend   [CH_NUM]   sticky event flag
// Revision : 1.0 - initial release
// ============================================================================
module sync_level2pulse_mc #(
  parameter int CH_NUM      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [CH_NUM-1:0]     sync_in,
  input  logic [2*CH_NUM-1:0]   edge_mode,
  input  logic [FILT_W-1:0]     filt_cnt,
  input  logic [CH_NUM-1:0]     evt_clr,
  output logic [CH_NUM-1:0]     sync_out,
  output logic [CH_NUM-1:0]     sync_ack,
  output logic [CH_NUM-1:0]     evt_pend
);

  localparam logic [FILT_W-1:0] c_one       = FILT_W'(1);
  localparam logic [1:0]        c_mode_rise = 2'b00;
  localparam logic [1:0]        c_mode_fall = 2'b01;
  localparam logic [1:0]        c_mode_both = 2'b10;

  // Threshold terms are shared by every channel.
  logic              w_no_filt;
  logic [FILT_W-1:0] w_thresh;

  assign w_no_filt = (filt_cnt <= c_one);
  assign w_thresh  = filt_cnt - c_one;

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic [FILT_W-1:0]      r_cnt;
      logic                   r_filt_lvl;
      logic                   r_filt_dly;
      logic                   r_pend;
      logic                   w_sync_lvl;
      logic                   w_rise;
      logic                   w_fall;
      logic                   w_pulse;
      logic [1:0]             w_mode;

      // Plain shift chain: no logic between stages.
      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], sync_in[gi]};
        end
      end

      assign w_sync_lvl = r_sync[SYNC_STAGES-1];

      // Debounce: a differing level must persist until the counter reaches
      // the threshold. The >= compare lets a threshold lowered mid-count
      // accept the change on the next cycle instead of counting up to a
      // value it can never hit again.
      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          r_cnt      <= '0;
          r_filt_lvl <= 1'b0;
        end else if (w_sync_lvl == r_filt_lvl) begin
          r_cnt <= '0;
        end else if (w_no_filt || (r_cnt >= w_thresh)) begin
          r_filt_lvl <= w_sync_lvl;
          r_cnt      <= '0;
        end else begin
          r_cnt <= r_cnt + c_one;
        end
      end

      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          r_filt_dly <= 1'b0;
        end else begin
          r_filt_dly <= r_filt_lvl;
        end
      end

      assign w_rise = r_filt_lvl & ~r_filt_dly;
      assign w_fall = ~r_filt_lvl & r_filt_dly;
      assign w_mode = edge_mode[2*gi +: 2];

      always_comb begin
        w_pulse = 1'b0;
        case (w_mode)
          c_mode_rise: w_pulse = w_rise;
          c_mode_fall: w_pulse = w_fall;
          c_mode_both: w_pulse = w_rise | w_fall;
          default:     w_pulse = 1'b0;
        endcase
      end

      // Set has priority over clear so a coincident event is never lost.
      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          r_pend <= 1'b0;
        end else if (w_pulse) begin
          r_pend <= 1'b1;
        end else if (evt_clr[gi]) begin
          r_pend <= 1'b0;
        end
      end

      assign sync_out[gi] = w_pulse;
      assign sync_ack[gi] = r_filt_lvl;
      assign evt_pend[gi] = r_pend;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_level2pulse_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_level2pulse_mc
// Purpose  : Directed table-driven bench for sync_level2pulse_mc (4 channels,
//            2 sync stages, 4-bit filter) plus hand-written reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_level2pulse_mc;

  logic       clk;
  logic       rst_b;
  logic [3:0] sync_in;
  logic [7:0] edge_mode;
  logic [3:0] filt_cnt;
  logic [3:0] evt_clr;
  logic [3:0] sync_out;
  logic [3:0] sync_ack;
  logic [3:0] evt_pend;

  int total;
  int bad;

  sync_level2pulse_mc #(
    .CH_NUM      (4),
    .SYNC_STAGES (2),
    .FILT_W      (4)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .sync_in   (sync_in),
    .edge_mode (edge_mode),
    .filt_cnt  (filt_cnt),
    .evt_clr   (evt_clr),
    .sync_out  (sync_out),
    .sync_ack  (sync_ack),
    .evt_pend  (evt_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row = inputs held for one cycle and the outputs seen in that cycle.
  typedef struct packed {
    logic [3:0] si;
    logic [7:0] mode;
    logic [3:0] fc;
    logic [3:0] clr;
    logic [3:0] eo;
    logic [3:0] ea;
    logic [3:0] ep;
  } vec_t;

  vec_t tbl [64];
  int   n_vec;

  task automatic put(input int a, input int b, input logic [3:0] si,
                     input logic [7:0] mode, input logic [3:0] fc,
                     input logic [3:0] clr, input logic [3:0] eo,
                     input logic [3:0] ea, input logic [3:0] ep);
    for (int k = a; k <= b; k++) begin
      tbl[k] = '{si: si, mode: mode, fc: fc, clr: clr, eo: eo, ea: ea, ep: ep};
    end
    if (b + 1 > n_vec) n_vec = b + 1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [3:0] act,
                     input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int idx, input logic [3:0] eo,
                         input logic [3:0] ea, input logic [3:0] ep);
    chk({nm, ".out"},  idx, sync_out, eo);
    chk({nm, ".ack"},  idx, sync_ack, ea);
    chk({nm, ".pend"}, idx, evt_pend, ep);
  endtask

  // Asserts reset between edges and releases it on a falling edge, so the
  // next rising edge is the first capture edge.
  task automatic reset_pulse();
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1 chk_all("rst_now", 0, 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1 chk_all("in_rst", k, 4'h0, 4'h0, 4'h0);
    end
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    n_vec     = 0;
    rst_b     = 1'b0;
    sync_in   = 4'h0;
    edge_mode = 8'h00;
    filt_cnt  = 4'h0;
    evt_clr   = 4'h0;

    // ---- rise latency and clear on ch0, filt_cnt=0, mode 00 ----
    put( 0,  2, 4'h1, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    put( 3,  3, 4'h1, 8'h00, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0);
    put( 4,  4, 4'h1, 8'h00, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1);
    put( 5,  5, 4'h1, 8'h00, 4'h0, 4'h1, 4'h0, 4'h1, 4'h1);
    // ---- ch3: clear coincident with a new pulse, then a real clear ----
    put( 6,  8, 4'h9, 8'h00, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0);
    put( 9,  9, 4'h9, 8'h00, 4'h0, 4'h8, 4'h8, 4'h9, 4'h0);
    put(10, 10, 4'h9, 8'h00, 4'h0, 4'h8, 4'h0, 4'h9, 4'h8);
    put(11, 11, 4'h9, 8'h00, 4'h0, 4'h0, 4'h0, 4'h9, 4'h0);
    // ---- ch2 both-edge mode, 8-cycle high pulse ----
    put(12, 14, 4'hD, 8'h20, 4'h0, 4'h0, 4'h0, 4'h9, 4'h0);
    put(15, 15, 4'hD, 8'h20, 4'h0, 4'h0, 4'h4, 4'hD, 4'h0);
    put(16, 19, 4'hD, 8'h20, 4'h0, 4'h0, 4'h0, 4'hD, 4'h4);
    put(20, 22, 4'h9, 8'h20, 4'h0, 4'h0, 4'h0, 4'hD, 4'h4);
    put(23, 23, 4'h9, 8'h20, 4'h0, 4'h0, 4'h4, 4'h9, 4'h4);
    put(24, 24, 4'h9, 8'h20, 4'h0, 4'h4, 4'h0, 4'h9, 4'h4);
    put(25, 25, 4'h9, 8'h20, 4'h0, 4'h0, 4'h0, 4'h9, 4'h0);
    // ---- ch2 disabled: level still tracked, no pulses ----
    put(26, 28, 4'hD, 8'h30, 4'h0, 4'h0, 4'h0, 4'h9, 4'h0);
    put(29, 33, 4'hD, 8'h30, 4'h0, 4'h0, 4'h0, 4'hD, 4'h0);
    put(34, 36, 4'h9, 8'h30, 4'h0, 4'h0, 4'h0, 4'hD, 4'h0);
    put(37, 37, 4'h9, 8'h30, 4'h0, 4'h0, 4'h0, 4'h9, 4'h0);
    // ---- ch1 filt_cnt=4: 3-cycle glitch dropped, 4-cycle level accepted ----
    put(38, 40, 4'hB, 8'h30, 4'h4, 4'h0, 4'h0, 4'h9, 4'h0);
    put(41, 46, 4'h9, 8'h30, 4'h4, 4'h0, 4'h0, 4'h9, 4'h0);
    put(47, 52, 4'hB, 8'h30, 4'h4, 4'h0, 4'h0, 4'h9, 4'h0);
    put(53, 53, 4'hB, 8'h30, 4'h4, 4'h0, 4'h2, 4'hB, 4'h0);
    put(54, 55, 4'hB, 8'h30, 4'h4, 4'h0, 4'h0, 4'hB, 4'h2);

    #2 chk_all("reset_state", 0, 4'h0, 4'h0, 4'h0);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;

    for (int i = 0; i < n_vec; i++) begin
      @(negedge clk);
      sync_in   = tbl[i].si;
      edge_mode = tbl[i].mode;
      filt_cnt  = tbl[i].fc;
      evt_clr   = tbl[i].clr;
      #1 chk_all("vec", i, tbl[i].eo, tbl[i].ea, tbl[i].ep);
    end

    // ---- inputs high through reset, mode 00: one pulse on every channel ----
    evt_clr   = 4'h0;
    filt_cnt  = 4'h0;
    edge_mode = 8'h00;
    sync_in   = 4'hF;
    reset_pulse();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1 chk_all("hi_rst_rise", k, (k == 2) ? 4'hF : 4'h0,
                 (k >= 2) ? 4'hF : 4'h0, (k >= 3) ? 4'hF : 4'h0);
    end

    // ---- same with fall mode: level tracked, no pulse ----
    edge_mode = 8'h55;
    reset_pulse();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1 chk_all("hi_rst_fall", k, 4'h0, (k >= 2) ? 4'hF : 4'h0, 4'h0);
    end

    // ---- reset mid-filter on ch0, then full latency again ----
    edge_mode = 8'h00;
    sync_in   = 4'h0;
    reset_pulse();
    @(negedge clk);
    sync_in = 4'h8;
    repeat (5) @(negedge clk);
    filt_cnt = 4'h4;
    sync_in  = 4'h9;
    repeat (4) @(negedge clk);
    #1 chk_all("mid_filt", 0, 4'h0, 4'h8, 4'h8);
    #1 rst_b = 1'b0;
    #1 chk_all("mid_filt_rst", 0, 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1 chk_all("mid_filt_hold", k, 4'h0, 4'h0, 4'h0);
    end
    @(negedge clk);
    rst_b = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      #1 chk_all("post_rst", k, (k == 5) ? 4'h9 : 4'h0,
                 (k >= 5) ? 4'h9 : 4'h0, (k >= 6) ? 4'h9 : 4'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
